// File: rtl/cc_datadelay_arbiter_if.sv
// rtl/cc_datadelay_arbiter_if.sv - requester/arbiter bundle for the data-delay round-robin scheduler
interface cc_datadelay_arbiter_if #(
    parameter int DATAWIDTH_BUS = 8
);
    logic [3:0]               CC_DATADELAYARB_Req_InBus;
    logic [DATAWIDTH_BUS-1:0] CC_DATADELAYARB_Data0_inBus;
    logic [DATAWIDTH_BUS-1:0] CC_DATADELAYARB_Data1_inBus;
    logic [DATAWIDTH_BUS-1:0] CC_DATADELAYARB_Data2_inBus;
    logic [DATAWIDTH_BUS-1:0] CC_DATADELAYARB_Data3_inBus;
    logic [3:0]               CC_DATADELAYARB_Grant_OutBus;
    logic [DATAWIDTH_BUS-1:0] CC_DATADELAYARB_DelayedData_outBus;
    logic                     CC_DATADELAYARB_SendDataSignal_Out;
    logic                     CC_DATADELAYARB_Busy_Out;

    modport master (
        output CC_DATADELAYARB_Req_InBus,
        output CC_DATADELAYARB_Data0_inBus,
        output CC_DATADELAYARB_Data1_inBus,
        output CC_DATADELAYARB_Data2_inBus,
        output CC_DATADELAYARB_Data3_inBus,
        input  CC_DATADELAYARB_Grant_OutBus,
        input  CC_DATADELAYARB_DelayedData_outBus,
        input  CC_DATADELAYARB_SendDataSignal_Out,
        input  CC_DATADELAYARB_Busy_Out
    );

    modport slave (
        input  CC_DATADELAYARB_Req_InBus,
        input  CC_DATADELAYARB_Data0_inBus,
        input  CC_DATADELAYARB_Data1_inBus,
        input  CC_DATADELAYARB_Data2_inBus,
        input  CC_DATADELAYARB_Data3_inBus,
        output CC_DATADELAYARB_Grant_OutBus,
        output CC_DATADELAYARB_DelayedData_outBus,
        output CC_DATADELAYARB_SendDataSignal_Out,
        output CC_DATADELAYARB_Busy_Out
    );
endinterface

// File: rtl/cc_datadelay_arbiter.sv
// rtl/cc_datadelay_arbiter.sv - four-way round-robin capture, hold and send-strobe scheduler
module cc_datadelay_arbiter #(
    parameter int DATAWIDTH_BUS = 8,
    parameter int DELAY_CYCLES  = 4,
    parameter int COUNTER_WIDTH = 8
) (
    input  logic                 CC_DATADELAYARB_CLOCK_50,
    input  logic                 CC_DATADELAYARB_RESET_InHigh,
    cc_datadelay_arbiter_if.slave bus
);
    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_WAIT = 2'd1;
    localparam logic [1:0] STATE_SEND = 2'd2;

    localparam logic [COUNTER_WIDTH-1:0] COUNT_ONE    = COUNTER_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0] COUNT_RELOAD = COUNTER_WIDTH'(DELAY_CYCLES - 1);

    logic [1:0]               state;
    logic [COUNTER_WIDTH-1:0] counter;
    logic [1:0]               last_grant;
    logic [3:0]               grant;
    logic [DATAWIDTH_BUS-1:0] data_q;
    logic                     send;
    logic                     busy;

    logic [1:0]               winner;
    logic [1:0]               cand;
    logic                     found;
    logic [DATAWIDTH_BUS-1:0] winner_data;

    // Search begins one past the last winner and wraps, so the last winner has lowest priority.
    always_comb begin
        winner = last_grant;
        cand   = last_grant;
        found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_grant + 2'(k);
            if (!found && bus.CC_DATADELAYARB_Req_InBus[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        winner_data = bus.CC_DATADELAYARB_Data0_inBus;
        case (winner)
            2'd0:    winner_data = bus.CC_DATADELAYARB_Data0_inBus;
            2'd1:    winner_data = bus.CC_DATADELAYARB_Data1_inBus;
            2'd2:    winner_data = bus.CC_DATADELAYARB_Data2_inBus;
            default: winner_data = bus.CC_DATADELAYARB_Data3_inBus;
        endcase
    end

    always_ff @(posedge CC_DATADELAYARB_CLOCK_50) begin
        if (CC_DATADELAYARB_RESET_InHigh) begin
            state      <= STATE_IDLE;
            counter    <= '0;
            last_grant <= 2'd3;
            grant      <= '0;
            data_q     <= '0;
            send       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            grant <= '0;
            send  <= 1'b0;
            case (state)
                STATE_IDLE: begin
                    if (|bus.CC_DATADELAYARB_Req_InBus) begin
                        data_q     <= winner_data;
                        counter    <= COUNT_RELOAD;
                        grant      <= 4'b0001 << winner;
                        last_grant <= winner;
                        state      <= STATE_WAIT;
                        busy       <= 1'b1;
                    end
                end
                STATE_WAIT: begin
                    if (counter != '0) begin
                        counter <= counter - COUNT_ONE;
                    end else begin
                        state <= STATE_SEND;
                        send  <= 1'b1;
                    end
                end
                STATE_SEND: begin
                    state <= STATE_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= STATE_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.CC_DATADELAYARB_Grant_OutBus       = grant;
    assign bus.CC_DATADELAYARB_DelayedData_outBus = data_q;
    assign bus.CC_DATADELAYARB_SendDataSignal_Out = send;
    assign bus.CC_DATADELAYARB_Busy_Out           = busy;
endmodule

// File: tb/tb_cc_datadelay_arbiter.sv
// tb/tb_cc_datadelay_arbiter.sv - vector table, directed sequences and random stimulus against a schedule model
module tb_cc_datadelay_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cc_datadelay_arbiter_if #(.DATAWIDTH_BUS(8)) if0 ();
    cc_datadelay_arbiter_if #(.DATAWIDTH_BUS(8)) if1 ();

    cc_datadelay_arbiter #(.DATAWIDTH_BUS(8), .DELAY_CYCLES(4), .COUNTER_WIDTH(8)) dut0 (
        .CC_DATADELAYARB_CLOCK_50     (clk),
        .CC_DATADELAYARB_RESET_InHigh (rst),
        .bus                          (if0)
    );

    cc_datadelay_arbiter #(.DATAWIDTH_BUS(8), .DELAY_CYCLES(1), .COUNTER_WIDTH(8)) dut1 (
        .CC_DATADELAYARB_CLOCK_50     (clk),
        .CC_DATADELAYARB_RESET_InHigh (rst),
        .bus                          (if1)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [7:0] d2;
        logic [3:0] eg;
        logic       es;
        logic       eb;
        logic [7:0] ed;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int dly[2] = '{4, 1};

    // Model: each capture is a scheduled transaction (grant cycle, send cycle, next free cycle).
    int         free_at[2] = '{0, 0};
    int         grant_t[2] = '{-100, -100};
    int         send_t[2]  = '{-100, -100};
    int         last[2]    = '{3, 3};
    int         win[2]     = '{0, 0};
    logic [7:0] dreg[2];
    logic [3:0] exp_g[2];
    logic       exp_s[2];
    logic       exp_b[2];
    logic [7:0] exp_d[2];

    int gq[$];
    int gc[$];

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s dut%0d cycle %0d got=%h exp=%h", name, idx, cyc, got, want);
        end
    endtask

    task automatic model_step(input int i, input logic r, input logic [3:0] q, input logic [31:0] dw);
        int t;
        int c;
        int idx;
        t = cyc;
        c = t + 1;
        if (r) begin
            last[i]    = 3;
            free_at[i] = c;
            grant_t[i] = -100;
            send_t[i]  = -100;
            dreg[i]    = 8'h00;
        end else if (t >= free_at[i] && q != 4'b0000) begin
            for (int k = 4; k >= 1; k--) begin
                idx = (last[i] + k) % 4;
                if (q[idx]) win[i] = idx;
            end
            grant_t[i] = c;
            send_t[i]  = t + dly[i] + 1;
            free_at[i] = t + dly[i] + 2;
            dreg[i]    = dw[8*win[i] +: 8];
            last[i]    = win[i];
        end
        exp_g[i] = (c == grant_t[i]) ? (4'b0001 << win[i]) : 4'b0000;
        exp_s[i] = (c == send_t[i]);
        exp_b[i] = (c >= grant_t[i]) && (c <= send_t[i]);
        exp_d[i] = dreg[i];
    endtask

    function automatic int gidx(input logic [3:0] g);
        int r;
        r = -1;
        for (int k = 0; k < 4; k++) if (g[k]) r = k;
        return r;
    endfunction

    task automatic drive_cycle(input logic r, input logic [3:0] q, input logic [31:0] dw);
        rst = r;
        if0.CC_DATADELAYARB_Req_InBus   = q;
        if0.CC_DATADELAYARB_Data0_inBus = dw[7:0];
        if0.CC_DATADELAYARB_Data1_inBus = dw[15:8];
        if0.CC_DATADELAYARB_Data2_inBus = dw[23:16];
        if0.CC_DATADELAYARB_Data3_inBus = dw[31:24];
        if1.CC_DATADELAYARB_Req_InBus   = q;
        if1.CC_DATADELAYARB_Data0_inBus = dw[7:0];
        if1.CC_DATADELAYARB_Data1_inBus = dw[15:8];
        if1.CC_DATADELAYARB_Data2_inBus = dw[23:16];
        if1.CC_DATADELAYARB_Data3_inBus = dw[31:24];
        model_step(0, r, q, dw);
        model_step(1, r, q, dw);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk("grant", 0, 32'(if0.CC_DATADELAYARB_Grant_OutBus), 32'(exp_g[0]));
        chk("send",  0, 32'(if0.CC_DATADELAYARB_SendDataSignal_Out), 32'(exp_s[0]));
        chk("busy",  0, 32'(if0.CC_DATADELAYARB_Busy_Out), 32'(exp_b[0]));
        chk("data",  0, 32'(if0.CC_DATADELAYARB_DelayedData_outBus), 32'(exp_d[0]));
        chk("grant", 1, 32'(if1.CC_DATADELAYARB_Grant_OutBus), 32'(exp_g[1]));
        chk("send",  1, 32'(if1.CC_DATADELAYARB_SendDataSignal_Out), 32'(exp_s[1]));
        chk("busy",  1, 32'(if1.CC_DATADELAYARB_Busy_Out), 32'(exp_b[1]));
        chk("data",  1, 32'(if1.CC_DATADELAYARB_DelayedData_outBus), 32'(exp_d[1]));
        if (if0.CC_DATADELAYARB_Grant_OutBus != 4'b0000) begin
            gq.push_back(gidx(if0.CC_DATADELAYARB_Grant_OutBus));
            gc.push_back(cyc);
        end
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1'b1, 4'b0000, 8'h00, 4'b0000, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 4'b0100, 8'hA5, 4'b0100, 1'b0, 1'b1, 8'hA5};
        tbl[2] = '{1'b0, 4'b0000, 8'h5A, 4'b0000, 1'b0, 1'b1, 8'hA5};
        tbl[3] = '{1'b0, 4'b0100, 8'h5A, 4'b0000, 1'b0, 1'b1, 8'hA5};
        tbl[4] = '{1'b0, 4'b0000, 8'h00, 4'b0000, 1'b0, 1'b1, 8'hA5};
        tbl[5] = '{1'b0, 4'b0000, 8'h00, 4'b0000, 1'b1, 1'b1, 8'hA5};
        tbl[6] = '{1'b0, 4'b0000, 8'h00, 4'b0000, 1'b0, 1'b0, 8'hA5};
        tbl[7] = '{1'b0, 4'b0000, 8'h00, 4'b0000, 1'b0, 1'b0, 8'hA5};

        for (int v = 0; v < 8; v++) begin
            drive_cycle(tbl[v].rst, tbl[v].req, {8'h00, tbl[v].d2, 16'h0000});
            chk("tbl_grant", 0, 32'(if0.CC_DATADELAYARB_Grant_OutBus), 32'(tbl[v].eg));
            chk("tbl_send",  0, 32'(if0.CC_DATADELAYARB_SendDataSignal_Out), 32'(tbl[v].es));
            chk("tbl_busy",  0, 32'(if0.CC_DATADELAYARB_Busy_Out), 32'(tbl[v].eb));
            chk("tbl_data",  0, 32'(if0.CC_DATADELAYARB_DelayedData_outBus), 32'(tbl[v].ed));
        end

        // Continuous requests from everyone: strict rotation, one word per six cycles.
        drive_cycle(1'b1, 4'b0000, 32'h0);
        gq.delete();
        gc.delete();
        for (int n = 0; n < 30; n++) drive_cycle(1'b0, 4'b1111, 32'h44332211);
        chk("rr_count", 0, 32'(gq.size() >= 5), 32'd1);
        if (gq.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk("rr_order", 0, 32'(gq[k]), 32'(k % 4));
            for (int k = 1; k < 5; k++) chk("rr_gap", 0, 32'(gc[k] - gc[k-1]), 32'd6);
        end

        // Wrap-around after requester 2 was last served.
        drive_cycle(1'b1, 4'b0000, 32'h0);
        drive_cycle(1'b0, 4'b0100, 32'h00C00000);
        for (int n = 0; n < 6; n++) drive_cycle(1'b0, 4'b0000, 32'h0);
        gq.delete();
        gc.delete();
        for (int n = 0; n < 10; n++) drive_cycle(1'b0, 4'b0011, 32'h0000B2B1);
        chk("wrap_count", 0, 32'(gq.size() >= 2), 32'd1);
        if (gq.size() >= 2) begin
            chk("wrap_first",  0, 32'(gq[0]), 32'd0);
            chk("wrap_second", 0, 32'(gq[1]), 32'd1);
        end

        // Inputs changing while the word is held must not disturb it.
        drive_cycle(1'b1, 4'b0000, 32'h0);
        drive_cycle(1'b0, 4'b0001, 32'h00000011);
        for (int n = 0; n < 4; n++) drive_cycle(1'b0, 4'b1110, $urandom);
        chk("hold_data", 0, 32'(if0.CC_DATADELAYARB_DelayedData_outBus), 32'h11);
        for (int n = 0; n < 3; n++) drive_cycle(1'b0, 4'b0000, 32'h0);

        // Reset during the third hold cycle aborts the word; requester 3 is then served.
        drive_cycle(1'b0, 4'b0010, 32'h00002200);
        drive_cycle(1'b0, 4'b0000, 32'h0);
        drive_cycle(1'b0, 4'b0000, 32'h0);
        drive_cycle(1'b1, 4'b0000, 32'h0);
        chk("abort_busy", 0, 32'(if0.CC_DATADELAYARB_Busy_Out), 32'd0);
        drive_cycle(1'b0, 4'b1000, 32'h77000000);
        chk("post_reset_grant", 0, 32'(if0.CC_DATADELAYARB_Grant_OutBus), 32'b1000);
        for (int n = 0; n < 6; n++) drive_cycle(1'b0, 4'b0000, 32'h0);

        for (int n = 0; n < 400; n++) begin
            logic       r;
            logic [3:0] q;
            r = ($urandom_range(0, 60) == 0);
            q = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            drive_cycle(r, q, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cc_datadelay_arbiter.md
# cc_datadelay_arbiter

Round-robin scheduler that shares one delayed-data send path between four requesters. It captures the winning requester's data word and holds it for a programmable number of cycles. It then issues a one-cycle send strobe together with the held word on the shared bus that feeds the downstream data-delay stage. It sits between the game-logic producers (e.g. player, enemy, score updaters) and the single data-delay/send stage.

## Interface
- DATAWIDTH_BUS, 8, width of each data word
- DELAY_CYCLES, 4, cycles the captured word is held before the send strobe; legal range 1..2^COUNTER_WIDTH-1
- COUNTER_WIDTH, 8, width of the internal hold counter

Clock and reset: one clock; reset is synchronous and active-high.
- CC_DATADELAYARB_CLOCK_50  in  1  system clock; all state changes on its rising edge
- CC_DATADELAYARB_RESET_InHigh  in  1  synchronous active-high reset
- CC_DATADELAYARB_Req_InBus  in  4  request per requester; bit i = requester i
- CC_DATADELAYARB_Data0_inBus .. CC_DATADELAYARB_Data3_inBus  in  DATAWIDTH_BUS each  data offered by requesters 0..3
- CC_DATADELAYARB_Grant_OutBus  out  4  one-hot acknowledge, high for exactly one cycle on capture
- CC_DATADELAYARB_DelayedData_outBus  out  DATAWIDTH_BUS  captured word; held between captures
- CC_DATADELAYARB_SendDataSignal_Out  out  1  one-cycle send strobe to the downstream delay stage
- CC_DATADELAYARB_Busy_Out  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, WAIT, SEND. All outputs are driven from registers; there is no combinational path from inputs to outputs.
- IDLE: if Req_InBus != 0, select the winner, capture its data into the data register, load counter = DELAY_CYCLES-1, set Grant bit, and go to WAIT. Otherwise stay in IDLE.
- Round robin: the search starts at (last_grant+1) mod 4 and wraps. last_grant updates on every capture.
- WAIT: Grant is high only in the first WAIT cycle. While counter != 0, decrement the counter. When counter == 0, go to SEND.
- SEND: SendDataSignal_Out = 1 for one cycle, then return to IDLE.
- Requests are sampled only in IDLE. Requests that change during WAIT or SEND are ignored.
- A requester must drop Req after its Grant. A request still held when the FSM returns to IDLE is arbitrated again under normal round-robin order.
- DelayedData_outBus changes only on capture. It keeps its value through SEND and IDLE until the next capture.
- Busy_Out = 1 in WAIT and SEND.

## Timing
- Reset values: state IDLE, Grant 0, SendDataSignal 0, DelayedData 0, Busy 0, counter 0, last_grant = 3, so requester 0 has first priority after reset.
- Request sampled in IDLE at cycle t:
  - Grant and new data valid in cycle t+1.
  - WAIT covers cycles t+1 .. t+DELAY_CYCLES.
  - SEND strobe in cycle t+DELAY_CYCLES+1.
  - IDLE in cycle t+DELAY_CYCLES+2.
  - Earliest next Grant is t+DELAY_CYCLES+3.
- DELAY_CYCLES = 1: Grant cycle is also the last WAIT cycle; SEND follows directly.
- Throughput: one word per DELAY_CYCLES+2 cycles under continuous requests.
- Simultaneous requests: exactly one Grant bit is set, chosen by the round-robin rule. Grant is never multi-hot.
- Reset asserted mid-operation (WAIT or SEND) forces reset values on the next edge. No SEND strobe is issued for the aborted word.
- Reset has priority over request sampling in the same cycle.

## Test plan
- Reset, then Req=4'b0100 with Data2=8'hA5 for one cycle (DELAY_CYCLES=4) -> Grant=4'b0100 on the next cycle; SEND pulse 5 cycles after the sample; DelayedData=8'hA5 from the Grant cycle onward.
- Req=4'b1111 held continuously, data distinct per requester -> Grant order 0,1,2,3,0, with Grants 6 cycles apart; each SEND carries the matching word.
- Last grant 2, then Req=4'b0011 -> Grant=4'b0001 (wrap-around). Next arbitration with the same Req -> Grant=4'b0010.
- Change Req and Data inputs during WAIT -> DelayedData is unchanged, no extra Grant, and the SEND timing is unchanged.
- Assert reset in the 3rd WAIT cycle -> next cycle all outputs 0 and Busy=0, no SEND pulse; the next Req=4'b1000 after reset is granted (priority starts at requester 0 and searches to 3).
- DELAY_CYCLES=1, Req=4'b0001 -> Grant at t+1, SEND at t+2, Busy high for exactly 2 cycles.
